// File: rtl/hex_scan_driver.sv
// Multiplexed N-digit hex display driver: one shared segment bus, one-hot digit select,
// guard-timed scanning, leading-zero blanking, frame-boundary updates. Optional DP via HEX_SCAN_DP_EN.
module hex_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 2,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] val,
    input  logic                    load,
    input  logic                    blank_lz,
`ifdef HEX_SCAN_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    // Everything is built active-low internally; POL flips it for active-high boards.
    localparam logic                  POL     = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [6:0]            SEG_OFF = 7'h7F ^ {7{POL}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{1'b1}} ^ {NUM_DIGITS{POL}};

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    logic                    run_p0;
    logic [CW-1:0]           cnt_p0;
    logic [IW-1:0]           idx_p0;
    logic [4*NUM_DIGITS-1:0] pend_p0;
    logic [4*NUM_DIGITS-1:0] disp_p0;
    logic                    pend_vld_p0;
    logic                    step;
    logic                    wrap;

    assign step = run_p0 && (cnt_p0 == CNT_LAST);
    assign wrap = step && (idx_p0 == IDX_LAST);

    // Stage p0: reset release synchroniser, prescaler, digit index, pend/disp capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_p0 <= 1'b0;
        end else begin
            run_p0 <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0      <= '0;
            idx_p0      <= '0;
            pend_p0     <= '0;
            disp_p0     <= '0;
            pend_vld_p0 <= 1'b0;
        end else if (run_p0) begin
            cnt_p0 <= step ? '0 : cnt_p0 + 1'b1;
            if (step) begin
                idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
            end
            if (load) begin
                pend_p0 <= val;
            end
            // A load on the wrap cycle goes straight to disp rather than waiting a frame.
            if (wrap) begin
                disp_p0     <= load ? val : (pend_vld_p0 ? pend_p0 : disp_p0);
                pend_vld_p0 <= 1'b0;
            end else if (load) begin
                pend_vld_p0 <= 1'b1;
            end
        end
    end

`ifdef HEX_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] pend_dp_p0;
    logic [NUM_DIGITS-1:0] disp_dp_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dp_p0 <= '0;
            disp_dp_p0 <= '0;
        end else if (run_p0) begin
            if (load) begin
                pend_dp_p0 <= dp_in;
            end
            if (wrap) begin
                disp_dp_p0 <= load ? dp_in : (pend_vld_p0 ? pend_dp_p0 : disp_dp_p0);
            end
        end
    end
`endif

    logic [3:0]            nib;
    logic                  lz_all;
    logic                  blank;
    logic [NUM_DIGITS-1:0] dig_on;
    logic [6:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] dig_nxt;
    logic                  dp_on;

    // Walk from the top digit down so lz_all covers digits NUM_DIGITS-1..i at step i.
    always_comb begin
        nib    = 4'h0;
        lz_all = 1'b1;
        blank  = 1'b0;
        dig_on = '0;
        dp_on  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_all = lz_all && (disp_p0[4*i +: 4] == 4'h0);
            if (idx_p0 == IW'(i)) begin
                nib       = disp_p0[4*i +: 4];
                blank     = blank_lz && (i != 0) && lz_all;
                dig_on[i] = 1'b1;
`ifdef HEX_SCAN_DP_EN
                dp_on     = disp_dp_p0[i];
`endif
            end
        end
        seg_nxt = blank ? 7'h7F : decode(nib);
        dig_nxt = (cnt_p0 < CNT_GUARD) ? {NUM_DIGITS{1'b1}} : ~dig_on;
    end

    // Stage p1: registered pin drivers, one cycle behind the index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dig_sel    <= DIG_OFF;
            frame_done <= 1'b0;
        end else if (run_p0) begin
            seg        <= seg_nxt ^ {7{POL}};
            dig_sel    <= dig_nxt ^ {NUM_DIGITS{POL}};
            frame_done <= wrap;
        end
    end

`ifdef HEX_SCAN_DP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp <= 1'b1 ^ POL;
        end else if (run_p0) begin
            dp <= (~dp_on) ^ POL;
        end
    end
`else
    logic unused_dp;
    assign unused_dp = dp_on;
`endif

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver: 4 digits, 4-cycle dwell, 1-cycle guard, active-low pins.
module tb_hex_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] val = 16'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hex_scan_driver #(
        .NUM_DIGITS(4),
        .SCAN_DIV(4),
        .GUARD(1),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .val(val),
        .load(load),
        .blank_lz(blank_lz),
        .seg(seg),
        .dig_sel(dig_sel),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the first cycle of a frame (frame_done high), bounded.
    task automatic wait_frame();
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("frame_sync", {31'b0, frame_done}, 32'd1);
    endtask

    // Called in the frame_done cycle; checks the 16 cycles that follow.
    // ld_at >= 0 drives a one-cycle load of ld_val after sample ld_at.
    task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3,
                               input int ld_at, input logic [15:0] ld_val);
        logic [6:0] es [4];
        logic [3:0] ed;
        es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                ed = (c == 0) ? 4'hF : ~(4'b0001 << d);
                chk($sformatf("seg_d%0d_c%0d", d, c), {25'b0, seg}, {25'b0, es[d]});
                chk($sformatf("dig_d%0d_c%0d", d, c), {28'b0, dig_sel}, {28'b0, ed});
                chk($sformatf("fd_d%0d_c%0d", d, c), {31'b0, frame_done},
                    {31'b0, (d == 3 && c == 3)});
                if (d * 4 + c == ld_at) begin
                    load = 1'b1;
                    val  = ld_val;
                end else begin
                    load = 1'b0;
                end
            end
        end
    endtask

    initial begin
        // Reset state, then first digit-0 select on the 3rd clock after release
        repeat (2) @(negedge clk);
        chk("rst_seg", {25'b0, seg}, 32'h7F);
        chk("rst_dig", {28'b0, dig_sel}, 32'hF);
        chk("rst_fd", {31'b0, frame_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel1_dig", {28'b0, dig_sel}, 32'hF);
        @(negedge clk);
        chk("rel2_dig", {28'b0, dig_sel}, 32'hF);
        @(negedge clk);
        chk("rel3_dig", {28'b0, dig_sel}, 32'hE);

        // Plain decode
        val = 16'h12AF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
        check_frame(7'h0E, 7'h08, 7'h24, 7'h79, -1, 16'h0);

        // Leading-zero blanking
        blank_lz = 1'b1; val = 16'h0030; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
        check_frame(7'h40, 7'h30, 7'h7F, 7'h7F, -1, 16'h0);
        val = 16'h0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
        check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, -1, 16'h0);

        // Two loads inside one frame: frame unchanged, last load wins next frame
        val = 16'h1111; load = 1'b1;
        check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 8, 16'h2222);
        // Load on the wrap cycle takes effect at that wrap
        check_frame(7'h24, 7'h24, 7'h24, 7'h24, 14, 16'h8888);
        check_frame(7'h00, 7'h00, 7'h00, 7'h00, -1, 16'h0);

        // Reset during digit 2's dwell
        repeat (10) @(negedge clk);
        chk("pre_rst_dig", {28'b0, dig_sel}, 32'hB);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", {25'b0, seg}, 32'h7F);
        chk("mid_rst_dig", {28'b0, dig_sel}, 32'hF);
        chk("mid_rst_fd", {31'b0, frame_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_fd_%0d", k), {31'b0, frame_done}, {31'b0, (k == 17)});
            if (k == 1) chk("post_rst_seg1", {25'b0, seg}, 32'h7F);
            if (k == 2) chk("post_rst_dig2", {28'b0, dig_sel}, 32'hF);
            if (k == 2) chk("post_rst_seg2", {25'b0, seg}, 32'h40);
            if (k == 3) chk("post_rst_dig3", {28'b0, dig_sel}, 32'hE);
            if (k == 3) chk("post_rst_seg3", {25'b0, seg}, 32'h40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
